jk_flip_flop: RTL and testbench

//  - Synchronous JK flip-flop bank: WIDTH independent JK storage bits sharing one clock.
//  - Each bit has a synchronous reset and a synchronous set.
//  - General-purpose state element; WIDTH=1 gives the classic single JK flop.

---
 rtl/jkff_pkg.sv | 23 ++
 rtl/jk_cell.sv | 53 +++++
 rtl/jk_flip_flop.sv | 33 +++
 tb/tb_jk_flip_flop.sv | 105 ++++++++++
 4 files changed

// File: rtl/jkff_pkg.sv
// Shared types and the per-bit JK next-state function for the jk_flip_flop bank.
package jkff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_mode_t;

  function automatic logic jk_next(input logic q, input jk_mode_t m);
    logic nq;
    case (m)
      JK_HOLD: nq = q;
      JK_CLR:  nq = 1'b0;
      JK_SET:  nq = 1'b1;
      JK_TOG:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK register with synchronous reset and set.
// Clock enable port exists only when JKFF_CLK_ENABLE_EN is defined.
import jkff_pkg::*;

module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic set,
`ifdef JKFF_CLK_ENABLE_EN
  input  logic ce,
`endif
  input  logic j,
  input  logic k,
  output logic q
);

  logic     q_r;
  logic     next_s;
  logic     ce_s;
  jk_mode_t mode_s;

`ifdef JKFF_CLK_ENABLE_EN
  assign ce_s = ce;
`else
  assign ce_s = 1'b1;
`endif

  assign mode_s = jk_mode_t'({j, k});

  // Next state below reset: ce gates both set and the JK function.
  always_comb begin
    next_s = q_r;
    if (!ce_s) begin
      next_s = q_r;
    end else if (set) begin
      next_s = 1'b1;
    end else begin
      next_s = jk_next(q_r, mode_s);
    end
  end

  // State register; reset overrides everything including ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 1'b0;
    end else begin
      q_r <= next_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent JK flops sharing clock, reset and set.
// Optional clock enable port via macro JKFF_CLK_ENABLE_EN.
import jkff_pkg::*;

module jk_flip_flop #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
`ifdef JKFF_CLK_ENABLE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .set   (set),
`ifdef JKFF_CLK_ENABLE_EN
      .ce    (ce),
`endif
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed self-checking bench for jk_flip_flop (WIDTH=4; ce tests when JKFF_CLK_ENABLE_EN is defined).
module tb_jk_flip_flop;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         set = 1'b0;
`ifdef JKFF_CLK_ENABLE_EN
  logic         ce = 1'b1;
`endif
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] q;

  int checks = 0;
  int errors = 0;

  jk_flip_flop #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .set   (set),
`ifdef JKFF_CLK_ENABLE_EN
    .ce    (ce),
`endif
    .j     (j),
    .k     (k),
    .q     (q)
  );

  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then compare q 1 time unit later.
  task automatic step(input string tag, input logic r, input logic s,
                      input logic [W-1:0] jv, input logic [W-1:0] kv,
                      input logic [W-1:0] exp);
    reset = r;
    set   = s;
    j     = jv;
    k     = kv;
    @(posedge clk);
    #1;
    checks++;
    assert (q === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, q, exp);
    end
  endtask

  initial begin
    logic [W-1:0] rj;
    logic [W-1:0] rk;
    rj = W'($urandom_range(15, 0));
    rk = W'($urandom_range(15, 0));
    @(negedge clk);

    // reset beats set, random j/k
    step("rst_and_set",   1'b1, 1'b1, rj,    rk,    4'b0000);
    step("rst_hold",      1'b1, 1'b0, 4'hF,  4'h0,  4'b0000);
    step("set",           1'b0, 1'b1, 4'h0,  4'h0,  4'b1111);
    step("set_then_hold", 1'b0, 1'b0, 4'h0,  4'h0,  4'b1111);
    step("rst_again",     1'b1, 1'b0, 4'h0,  4'h0,  4'b0000);

    // JK table on every bit
    step("jk10", 1'b0, 1'b0, 4'hF, 4'h0, 4'b1111);
    step("jk00", 1'b0, 1'b0, 4'h0, 4'h0, 4'b1111);
    step("jk01", 1'b0, 1'b0, 4'h0, 4'hF, 4'b0000);
    step("jk11a", 1'b0, 1'b0, 4'hF, 4'hF, 4'b1111);
    step("jk11b", 1'b0, 1'b0, 4'hF, 4'hF, 4'b0000);

    // six toggles from 0
    step("tog1", 1'b0, 1'b0, 4'hF, 4'hF, 4'b1111);
    step("tog2", 1'b0, 1'b0, 4'hF, 4'hF, 4'b0000);
    step("tog3", 1'b0, 1'b0, 4'hF, 4'hF, 4'b1111);
    step("tog4", 1'b0, 1'b0, 4'hF, 4'hF, 4'b0000);
    step("tog5", 1'b0, 1'b0, 4'hF, 4'hF, 4'b1111);
    step("tog6", 1'b0, 1'b0, 4'hF, 4'hF, 4'b0000);

    // reset where toggle would reach 1, then resume
    step("rst_mid_tog",  1'b1, 1'b0, 4'hF, 4'hF, 4'b0000);
    step("tog_after_rst", 1'b0, 1'b0, 4'hF, 4'hF, 4'b1111);
    step("tog_next",     1'b0, 1'b0, 4'hF, 4'hF, 4'b0000);
    // set where toggle would reach 1 from 0 -> still 1, then toggles to 0
    step("set_mid_tog",  1'b0, 1'b1, 4'hF, 4'hF, 4'b1111);
    step("tog_after_set", 1'b0, 1'b0, 4'hF, 4'hF, 4'b0000);

    // mixed per-bit modes: build 0101, then bit3 tog, bit2 set, bit1 clr, bit0 hold
    step("mix_load", 1'b0, 1'b0, 4'b0101, 4'b1010, 4'b0101);
    step("mix",      1'b0, 1'b0, 4'b1100, 4'b1010, 4'b1101);
    step("mix_again", 1'b0, 1'b0, 4'b1100, 4'b1010, 4'b0101);

`ifdef JKFF_CLK_ENABLE_EN
    ce = 1'b0;
    step("ce0_tog",  1'b0, 1'b0, 4'hF, 4'hF, 4'b0101);
    step("ce0_set",  1'b0, 1'b1, 4'h0, 4'h0, 4'b0101);
    step("ce0_rst",  1'b1, 1'b0, 4'h0, 4'h0, 4'b0000);
    ce = 1'b1;
    step("ce1_set",  1'b0, 1'b1, 4'h0, 4'h0, 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
